// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the scalar/vector register file: two buffered sources, round-robin grant,
// registered write port and a pending-write scoreboard. Optional stall counter: WB_STALL_CNT_EN.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int LANES  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  // Handshake: a source transfers on a posedge where src_valid && src_ready are both high;
  // src_ready depends only on internal state, never on src_valid.
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [ADDR_W-1:0]         alu_addr,
  input  logic                      alu_vec,
  input  logic [LANES*DATA_W-1:0]   alu_data,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [ADDR_W-1:0]         mem_addr,
  input  logic                      mem_vec,
  input  logic [LANES*DATA_W-1:0]   mem_data,
  input  logic                      iss_valid,
  input  logic [ADDR_W-1:0]         iss_addr,
  input  logic                      iss_vec,
  input  logic [ADDR_W-1:0]         chk_addr1,
  input  logic [ADDR_W-1:0]         chk_addr2,
  input  logic                      chk_vec1,
  input  logic                      chk_vec2,
  output logic                      chk_busy1,
  output logic                      chk_busy2,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_wa,
  output logic [LANES*DATA_W-1:0]   rf_wd,
  output logic                      rf_wsel,
  output logic                      err_pc_wr,
  output logic [15:0]               stall_cnt
);

  localparam int WD_W = LANES * DATA_W;
  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ADDR = {ADDR_W{1'b1}};

  logic              alu_full, mem_full;
  logic [ADDR_W-1:0] alu_addr_q, mem_addr_q;
  logic              alu_vec_q, mem_vec_q;
  logic [WD_W-1:0]   alu_data_q, mem_data_q;
  logic              ptr_mem;
  logic              gnt_alu, gnt_mem, gnt_any;
  logic [ADDR_W-1:0] g_addr;
  logic              g_vec, g_pc;
  logic [WD_W-1:0]   g_data, g_wd;
  logic [NREG-2:0]   sb_s;
  logic [NREG-1:0]   sb_v;
  logic [NREG-1:0]   sb_s_rd;

  // When both buffers hold data the source that did not win last time is served.
  assign gnt_alu = alu_full && (!mem_full || ptr_mem);
  assign gnt_mem = mem_full && (!alu_full || !ptr_mem);
  assign gnt_any = gnt_alu || gnt_mem;

  assign alu_ready = !alu_full || gnt_alu;
  assign mem_ready = !mem_full || gnt_mem;

  assign g_addr = gnt_alu ? alu_addr_q : mem_addr_q;
  assign g_vec  = gnt_alu ? alu_vec_q  : mem_vec_q;
  assign g_data = gnt_alu ? alu_data_q : mem_data_q;
  assign g_pc   = !g_vec && (g_addr == PC_ADDR);

  // Scalar writes carry only the top lane; the others are zeroed.
  always_comb begin
    g_wd = g_data;
    if (!g_vec) begin
      g_wd = '0;
      g_wd[WD_W-1 -: DATA_W] = g_data[WD_W-1 -: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_full   <= 1'b0;
      alu_addr_q <= '0;
      alu_vec_q  <= 1'b0;
      alu_data_q <= '0;
      mem_full   <= 1'b0;
      mem_addr_q <= '0;
      mem_vec_q  <= 1'b0;
      mem_data_q <= '0;
      ptr_mem    <= 1'b1;
    end else begin
      if (alu_valid && alu_ready) begin
        alu_full   <= 1'b1;
        alu_addr_q <= alu_addr;
        alu_vec_q  <= alu_vec;
        alu_data_q <= alu_data;
      end else if (gnt_alu) begin
        alu_full <= 1'b0;
      end
      if (mem_valid && mem_ready) begin
        mem_full   <= 1'b1;
        mem_addr_q <= mem_addr;
        mem_vec_q  <= mem_vec;
        mem_data_q <= mem_data;
      end else if (gnt_mem) begin
        mem_full <= 1'b0;
      end
      if (gnt_alu)
        ptr_mem <= 1'b0;
      else if (gnt_mem)
        ptr_mem <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we     <= 1'b0;
      rf_wa     <= '0;
      rf_wd     <= '0;
      rf_wsel   <= 1'b0;
      err_pc_wr <= 1'b0;
    end else begin
      rf_we <= gnt_any && !g_pc;
      if (gnt_any) begin
        rf_wa   <= g_addr;
        rf_wsel <= g_vec;
        rf_wd   <= g_wd;
      end
      if (gnt_any && g_pc)
        err_pc_wr <= 1'b1;
    end
  end

  // Clear is written first so a same-edge set on the same bit takes precedence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_s <= '0;
      sb_v <= '0;
    end else begin
      if (rf_we) begin
        if (rf_wsel)
          sb_v[rf_wa] <= 1'b0;
        else if (rf_wa != PC_ADDR)
          sb_s[rf_wa] <= 1'b0;
      end
      if (iss_valid) begin
        if (iss_vec)
          sb_v[iss_addr] <= 1'b1;
        else if (iss_addr != PC_ADDR)
          sb_s[iss_addr] <= 1'b1;
      end
    end
  end

  assign sb_s_rd   = {1'b0, sb_s};
  assign chk_busy1 = chk_vec1 ? sb_v[chk_addr1] : sb_s_rd[chk_addr1];
  assign chk_busy2 = chk_vec2 ? sb_v[chk_addr2] : sb_s_rd[chk_addr2];

`ifdef WB_STALL_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_q <= '0;
    else if (((alu_full && !gnt_alu) || (mem_full && !gnt_mem)) && (stall_q != 16'hFFFF))
      stall_q <= stall_q + 16'd1;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes are queued at acceptance and
// compared against the register-file port at each negedge where rf_we is high.
module tb_regfile_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int LANES  = 16;
  localparam int ADDR_W = 4;
  localparam int WD_W   = LANES * DATA_W;
  localparam int EW     = ADDR_W + 1 + WD_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              alu_valid = 1'b0, mem_valid = 1'b0, iss_valid = 1'b0;
  logic              alu_ready, mem_ready;
  logic [ADDR_W-1:0] alu_addr = '0, mem_addr = '0, iss_addr = '0;
  logic              alu_vec = 1'b0, mem_vec = 1'b0, iss_vec = 1'b0;
  logic [WD_W-1:0]   alu_data = '0, mem_data = '0;
  logic [ADDR_W-1:0] chk_addr1 = '0, chk_addr2 = '0;
  logic              chk_vec1 = 1'b0, chk_vec2 = 1'b0;
  logic              chk_busy1, chk_busy2;
  logic              rf_we, rf_wsel, err_pc_wr;
  logic [ADDR_W-1:0] rf_wa;
  logic [WD_W-1:0]   rf_wd;
  logic [15:0]       stall_cnt;

  logic [EW-1:0] exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_vec(alu_vec), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_vec(mem_vec), .mem_data(mem_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_vec(iss_vec),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .chk_vec1(chk_vec1), .chk_vec2(chk_vec2),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_wsel(rf_wsel),
    .err_pc_wr(err_pc_wr), .stall_cnt(stall_cnt)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WD_W-1:0] rand_data();
    logic [WD_W-1:0] d;
    for (int l = 0; l < LANES; l++) d[l*DATA_W +: DATA_W] = $urandom_range(32'hFFFF_FFFF, 0);
    return d;
  endfunction

  function automatic logic [WD_W-1:0] lane_index_data();
    logic [WD_W-1:0] d;
    for (int l = 0; l < LANES; l++) d[l*DATA_W +: DATA_W] = DATA_W'(l);
    return d;
  endfunction

  // Reference for what the file port should show for a given request.
  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic v, input logic [WD_W-1:0] d);
    logic [WD_W-1:0] wd;
    if (!v && a == 4'hF) return;
    wd = d;
    if (!v) begin
      wd = '0;
      wd[WD_W-1 -: DATA_W] = d[WD_W-1 -: DATA_W];
    end
    exp_q.push_back({a, v, wd});
  endtask

  // Driver: advance one cycle, queueing whatever each source hands over at this edge.
  task automatic step();
    logic acc_a, acc_m;
    #1;
    acc_a = alu_valid && alu_ready;
    acc_m = mem_valid && mem_ready;
    @(posedge clk);
    if (acc_a) push_exp(alu_addr, alu_vec, alu_data);
    if (acc_m) push_exp(mem_addr, mem_vec, mem_data);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    iss_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
  endtask

  // Scoreboard: every write seen on the file port must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && rf_we) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $error("FAIL unexpected_write observed wa=%0h wsel=%0b expected=no write", rf_wa, rf_wsel);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        assert ({rf_wa, rf_wsel, rf_wd} === e) n_pass++;
        else begin
          n_fail++;
          $error("FAIL write_data observed=%0h expected=%0h", {rf_wa, rf_wsel, rf_wd}, e);
        end
      end
    end
  end

  initial begin
    logic [15:0] exp_stall;
    apply_reset();
    check("reset_rf_we", rf_we, 0);
    check("reset_rf_wa", rf_wa, 0);
    check("reset_rf_wsel", rf_wsel, 0);
    check("reset_rf_wd_zero", rf_wd == '0, 1);
    check("reset_alu_ready", alu_ready, 1);
    check("reset_mem_ready", mem_ready, 1);
    check("reset_err", err_pc_wr, 0);
    check("reset_stall", stall_cnt, 0);

    // ALU only: vector 3, streamed three cycles
    alu_valid = 1'b1; alu_addr = 4'd3; alu_vec = 1'b1; alu_data = lane_index_data();
    for (int k = 0; k < 3; k++) begin
      #1 check("alu_only_ready", alu_ready, 1);
      step();
      check("alu_only_we", rf_we, (k == 0) ? 0 : 1);
    end
    alu_valid = 1'b0;
    repeat (3) step();
    check("alu_only_drained", exp_q.size(), 0);

    // Contention: ALU scalar 2 vs MEM vector 5, first tie goes to ALU after reset
    apply_reset();
    alu_valid = 1'b1; alu_addr = 4'd2; alu_vec = 1'b0;
    mem_valid = 1'b1; mem_addr = 4'd5; mem_vec = 1'b1;
    for (int k = 0; k < 6; k++) begin
      alu_data = rand_data();
      mem_data = rand_data();
      #1;
      check("contend_alu_ready", alu_ready, (k == 0) ? 1 : ((k % 2) == 1));
      check("contend_mem_ready", mem_ready, (k == 0) ? 1 : ((k % 2) == 0));
      step();
`ifdef WB_STALL_CNT_EN
      exp_stall = 16'(k);
`else
      exp_stall = 16'd0;
`endif
      check("contend_stall", stall_cnt, exp_stall);
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    repeat (4) step();
    check("contend_drained", exp_q.size(), 0);

    // Scalar write to PC address is dropped and flagged
    alu_valid = 1'b1; alu_addr = 4'hF; alu_vec = 1'b0;
    alu_data = '0; alu_data[WD_W-1 -: DATA_W] = 32'hDEAD;
    step();
    alu_valid = 1'b0;
    check("pc_err_before", err_pc_wr, 0);
    step();
    check("pc_slot_we", rf_we, 0);
    check("pc_err_set", err_pc_wr, 1);
    alu_valid = 1'b1; alu_addr = 4'd4; alu_data = rand_data();
    step();
    alu_valid = 1'b0;
    step();
    check("after_pc_we", rf_we, 1);
    step();
    check("pc_err_sticky", err_pc_wr, 1);
    check("pc_drained", exp_q.size(), 0);

    // Scoreboard set/check/clear
    iss_valid = 1'b1; iss_vec = 1'b1; iss_addr = 4'd7;
    step();
    iss_vec = 1'b0; iss_addr = 4'hF;
    step();
    iss_valid = 1'b0;
    chk_addr1 = 4'd7; chk_vec1 = 1'b1; chk_addr2 = 4'hF; chk_vec2 = 1'b0;
    #1;
    check("sb_vec7_busy", chk_busy1, 1);
    check("sb_pc_ignored", chk_busy2, 0);
    chk_vec1 = 1'b0;
    #1 check("sb_scalar7_free", chk_busy1, 0);
    chk_vec1 = 1'b1;
    mem_valid = 1'b1; mem_addr = 4'd7; mem_vec = 1'b1; mem_data = rand_data();
    step();
    mem_valid = 1'b0;
    step();
    check("sb_wr_we", rf_we, 1);
    check("sb_busy_during_we", chk_busy1, 1);
    step();
    check("sb_cleared", chk_busy1, 0);
    // set at the clearing edge must win
    iss_valid = 1'b1; iss_vec = 1'b1; iss_addr = 4'd7;
    step();
    iss_valid = 1'b0;
    mem_valid = 1'b1; mem_data = rand_data();
    step();
    mem_valid = 1'b0;
    step();
    iss_valid = 1'b1;
    step();
    iss_valid = 1'b0;
    check("sb_set_wins", chk_busy1, 1);
    chk_addr2 = 4'd9; chk_vec2 = 1'b1;
    iss_valid = 1'b1; iss_addr = 4'd9;
    step();
    iss_valid = 1'b0;
    check("sb_vec9_busy", chk_busy2, 1);
    check("sb_drained", exp_q.size(), 0);

    // Asynchronous reset while both buffers are full and a write is on the port
    alu_valid = 1'b1; alu_addr = 4'd1; alu_vec = 1'b1; alu_data = rand_data();
    mem_valid = 1'b1; mem_addr = 4'd6; mem_vec = 1'b1; mem_data = rand_data();
    repeat (3) step();
    check("mid_rst_we_before", rf_we, 1);
    #2 rst = 1'b1;
    exp_q.delete();
    alu_valid = 1'b0; mem_valid = 1'b0;
    #1;
    check("mid_rst_we", rf_we, 0);
    check("mid_rst_wa", rf_wa, 0);
    check("mid_rst_wsel", rf_wsel, 0);
    check("mid_rst_wd_zero", rf_wd == '0, 1);
    check("mid_rst_err", err_pc_wr, 0);
    check("mid_rst_stall", stall_cnt, 0);
    check("mid_rst_busy1", chk_busy1, 0);
    check("mid_rst_busy2", chk_busy2, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("post_rst_alu_ready", alu_ready, 1);
    check("post_rst_mem_ready", mem_ready, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("post_rst_no_we", rf_we, 0);
    end
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
